// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the rx packet parser.
// RX_PARSER_CHKSUM_EN adds the CHK state (checksum byte on the wire).
package rx_pkt_pkg;

   localparam logic [7:0] DEFAULT_SOF_BYTE  = 8'hA5;
   localparam int         MAX_PAYLOAD_LIMIT = 15;
   localparam int         CNT_W             = 8;

`ifdef RX_PARSER_CHKSUM_EN
   typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK} rx_pkt_state_t;
`else
   typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD} rx_pkt_state_t;
`endif

endpackage

// File: rtl/rx_packet_parser_sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high, holds at all-ones.
// Registered output, synchronous active-low reset to zero.
module sat_counter
   import rx_pkt_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/rx_packet_parser.sv
// Frames UART byte strobes into cmd/len/payload packets; output registered, held until pkt_ready.
// A completion while the output is held and not accepted is dropped; RX_PARSER_CHKSUM_EN adds checksum.
module rx_packet_parser
   import rx_pkt_pkg::*;
#(
   parameter int         MAX_PAYLOAD = 4,
   parameter logic [7:0] SOF_BYTE    = DEFAULT_SOF_BYTE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_data_ready,
   input  logic                     rx_endofpacket,
   output logic                     pkt_valid,
   input  logic                     pkt_ready,
   output logic [7:0]               pkt_cmd,
   output logic [3:0]               pkt_len,
   output logic [8*MAX_PAYLOAD-1:0] pkt_payload,
   output logic                     err_pulse,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   rx_pkt_state_t state, state_nxt;

   logic                     abort, complete, err, load, drop;
   logic                     len_bad, last_byte;
   logic [7:0]               sh_cmd;
   logic [3:0]               sh_len, sh_idx, fin_len;
   logic [8*MAX_PAYLOAD-1:0] sh_payload, fin_payload;
`ifdef RX_PARSER_CHKSUM_EN
   logic [7:0]               sh_chk;
`endif

   assign abort     = rx_endofpacket && (state != HUNT);
   assign len_bad   = rx_data > 8'(MAX_PAYLOAD);
   assign last_byte = (sh_idx == sh_len - 4'd1);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= HUNT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort)
         state_nxt = HUNT;
      else if (rx_data_ready) begin
         case (state)
            HUNT:    if (rx_data == SOF_BYTE) state_nxt = CMD;
            CMD:     state_nxt = LEN;
`ifdef RX_PARSER_CHKSUM_EN
            LEN:     state_nxt = len_bad ? HUNT : (rx_data == 8'd0) ? CHK : PAYLOAD;
            PAYLOAD: if (last_byte) state_nxt = CHK;
            CHK:     state_nxt = HUNT;
`else
            LEN:     state_nxt = (len_bad || rx_data == 8'd0) ? HUNT : PAYLOAD;
            PAYLOAD: if (last_byte) state_nxt = HUNT;
`endif
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      complete = 1'b0;
      err      = abort;
      if (!abort && rx_data_ready) begin
         case (state)
`ifdef RX_PARSER_CHKSUM_EN
            LEN:     err = len_bad;
            CHK: begin
               complete = (rx_data == sh_chk);
               err      = (rx_data != sh_chk);
            end
`else
            LEN: begin
               err      = len_bad;
               complete = !len_bad && (rx_data == 8'd0);
            end
            PAYLOAD: complete = last_byte;
`endif
            default: ;
         endcase
      end
   end

   // Final-byte view of the shadow, so a packet can complete on the strobe that finishes it.
   always_comb begin
      fin_payload = sh_payload;
      if (state == PAYLOAD) begin
         for (int i = 0; i < MAX_PAYLOAD; i++)
            if (sh_idx == 4'(i)) fin_payload[i*8 +: 8] = rx_data;
      end
   end

   assign fin_len = (state == LEN) ? rx_data[3:0] : sh_len;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_cmd     <= '0;
         sh_len     <= '0;
         sh_idx     <= '0;
         sh_payload <= '0;
`ifdef RX_PARSER_CHKSUM_EN
         sh_chk     <= '0;
`endif
      end else if (rx_data_ready && !abort) begin
         case (state)
            CMD: begin
               sh_cmd     <= rx_data;
               sh_payload <= '0;
`ifdef RX_PARSER_CHKSUM_EN
               sh_chk     <= rx_data;
`endif
            end
            LEN: begin
               sh_len <= rx_data[3:0];
               sh_idx <= '0;
`ifdef RX_PARSER_CHKSUM_EN
               sh_chk <= sh_chk ^ rx_data;
`endif
            end
            PAYLOAD: begin
               sh_payload <= fin_payload;
               sh_idx     <= sh_idx + 4'd1;
`ifdef RX_PARSER_CHKSUM_EN
               sh_chk     <= sh_chk ^ rx_data;
`endif
            end
            default: ;
         endcase
      end
   end

   assign load = complete && (!pkt_valid || pkt_ready);
   assign drop = complete && pkt_valid && !pkt_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_valid   <= 1'b0;
         pkt_cmd     <= '0;
         pkt_len     <= '0;
         pkt_payload <= '0;
         err_pulse   <= 1'b0;
      end else begin
         err_pulse <= err;
         if (load) begin
            pkt_valid   <= 1'b1;
            pkt_cmd     <= sh_cmd;
            pkt_len     <= fin_len;
            pkt_payload <= fin_payload;
         end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err),
      .count (err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop),
      .count (drop_cnt)
   );

endmodule

// File: doc/rx_packet_parser.md
# rx_packet_parser

Framing stage directly downstream of the UART byte receiver. Consumes its one-cycle byte strobes and end-of-packet pulse, assembles framed command packets (start byte, command, length, payload, checksum), and presents each validated packet to the game-control logic through a valid/ready handshake. Malformed, truncated or overrun packets are discarded and counted.

## Interface
- `MAX_PAYLOAD`, default 4: maximum payload bytes per packet (1..15).
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.
- `clk` in 1: system clock; same clock as the UART receiver.
- `rst_n` in 1: reset; synchronous, active-low.
- `rx_data` in 8: received byte; valid only while `rx_data_ready`=1.
- `rx_data_ready` in 1: one-cycle byte strobe.
- `rx_endofpacket` in 1: one-cycle line-gap pulse.
- `pkt_valid` out 1: packet available.
- `pkt_ready` in 1: consumer accepts packet.
- `pkt_cmd` out 8: command byte.
- `pkt_len` out 4: payload byte count.
- `pkt_payload` out 8*MAX_PAYLOAD: payload; byte 0 in bits [7:0]; unused bytes zero.
- `err_pulse` out 1: one-cycle pulse per discarded packet.
- `err_cnt` out 8: saturating count of framing/checksum errors.
- `drop_cnt` out 8: saturating count of good packets lost to a full output.

## Operation
- States: HUNT, CMD, LEN, PAYLOAD, CHK. Transitions happen only on `rx_data_ready`, except abort.
- HUNT: byte == SOF_BYTE -> CMD; other bytes ignored, no error.
- CMD: latch cmd, seed checksum = byte -> LEN.
- LEN: len > MAX_PAYLOAD -> error, HUNT. len == 0 -> CHK. Otherwise -> PAYLOAD with byte index 0.
- PAYLOAD: store byte at index, XOR it into checksum, increment index. After byte len-1 -> CHK.
- CHK: byte == XOR of cmd, len and all payload bytes -> complete; otherwise error. Both -> HUNT.
- Abort: `rx_endofpacket` while not in HUNT -> error, HUNT. Abort has priority over a simultaneous `rx_data_ready`, and that byte is dropped.
- Shadow buffer holds the packet being assembled. The output register is loaded only on completion.
- Completion with output free, or with output being accepted in the same cycle: load output, `pkt_valid`=1.
- Completion with `pkt_valid`=1 and `pkt_ready`=0: packet dropped; `drop_cnt`++; no `err_pulse`. The held packet is unchanged.
- Error: `err_pulse`=1 and `err_cnt`++. Counters saturate at 255.
- Reset values: state HUNT, `pkt_valid`=0, `pkt_cmd`/`pkt_len`/`pkt_payload`=0, `err_pulse`=0, both counters 0.
- Reset mid-packet discards the shadow buffer and the output.

## Timing
- `pkt_valid` rises on the clock edge that samples the final byte's `rx_data_ready` (registered; visible the next cycle).
- Transfer occurs on an edge where `pkt_valid` && `pkt_ready`. `pkt_valid` falls after that edge unless a completion occurs in the same cycle.
- Output fields are stable while `pkt_valid`=1.
- `err_pulse` is registered: high for exactly the one cycle after the offending strobe or abort.
- Back-to-back strobes on consecutive cycles must be handled, although the UART never produces them.

## Configuration
- `RX_PARSER_CHKSUM_EN` defined:
  - CHK state exists; checksum byte required and verified.
- `RX_PARSER_CHKSUM_EN` undefined:
  - no checksum byte on the wire and no CHK state;
  - packet completes on the last payload byte, or on the LEN byte when len == 0;
  - checksum-mismatch errors cannot occur.

## Structure
- Package `rx_pkt_pkg`:
  - state enum `rx_pkt_state_t`;
  - default `SOF_BYTE`;
  - `MAX_PAYLOAD_LIMIT` = 15;
  - `CNT_W` = 8.
- Sub-module `sat_counter`: CNT_W-bit saturating incrementer. Instantiated twice, for `err_cnt` and `drop_cnt`.

## Test plan
- Good packet A5 01 02 33 44, checksum 74 (01^02^33^44) -> `pkt_valid`, cmd 01, len 2, payload[15:0]=16'h4433, `err_cnt` 0.
- Same packet with checksum 75 -> no `pkt_valid`, one `err_pulse`, `err_cnt`=1; next good packet accepted.
- A5 01 05 with MAX_PAYLOAD=4 -> error, HUNT; following bytes ignored until the next A5.
- A5 07 03 11 followed by `rx_endofpacket` -> abort, `err_cnt`++, state HUNT.
- Hold `pkt_ready`=0, send two good packets -> first retained unchanged, `drop_cnt`=1.
- Then assert `pkt_ready` on the completion cycle of a third packet -> first transferred, third loaded, `pkt_valid` stays 1.
- Leading noise 00 FF, then A5 02 00 02 (len 0) -> packet cmd 02, len 0, payload 0, no error; without `RX_PARSER_CHKSUM_EN`, A5 02 00 alone completes.
